// File: rtl/snoop_pkt_recorder_pkg.sv
// Shared types for the snoop packet recorder: slot states, snoop FSM states, byte-increment decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package snoop_pkt_recorder_pkg;

    localparam int unsigned NUM_SLOTS = 2;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_FILLING = 2'd1,
        SLOT_READY   = 2'd2,
        SLOT_READING = 2'd3
    } slot_state_e;

    typedef enum logic [1:0] {
        SN_IDLE  = 2'd0,
        SN_OFFER = 2'd1,
        SN_FILL  = 2'd2
    } sn_state_e;

    // A zero increment stands for a full word of valid bytes.
    function automatic int unsigned decode_byte_inc(input int unsigned inc,
                                                    input int unsigned bytes_per_word);
        return (inc == 0) ? bytes_per_word : inc;
    endfunction

endpackage

// File: rtl/pkt_slot_ctrl.sv
// One buffer slot: FREE/FILLING/READY/READING state plus saturating byte-length accumulator.
// Latency: state and length update on the edge after their strobe; visible one cycle after READY.
// Backpressure: holds READY until taken and READING until released.
module pkt_slot_ctrl
    import snoop_pkt_recorder_pkg::*;
#(
    parameter int LEN_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 add_en,
    input  logic [LEN_WIDTH-1:0] add_bytes,
    input  logic                 done,
    input  logic                 take,
    input  logic                 rel,
    output slot_state_e          state,
    output logic [LEN_WIDTH-1:0] len,
    output logic                 visible
);

    slot_state_e          state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 vis_q, vis_d;
    logic [LEN_WIDTH:0]   len_sum;

    // Slot lifecycle and length accumulation; a write in the done cycle still counts.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        len_sum = {1'b0, len_q} + {1'b0, add_bytes};
        // READY is only exposed after a full cycle so the final memory write lands first.
        vis_d   = (state_q == SLOT_READY);
        case (state_q)
            SLOT_FREE: begin
                if (start) begin
                    state_d = SLOT_FILLING;
                    len_d   = '0;
                end
            end
            SLOT_FILLING: begin
                if (add_en) begin
                    len_d = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
                end
                if (done) begin
                    state_d = SLOT_READY;
                end
            end
            SLOT_READY: begin
                if (take) begin
                    state_d = SLOT_READING;
                end
            end
            SLOT_READING: begin
                if (rel) begin
                    state_d = SLOT_FREE;
                end
            end
            default: state_d = SLOT_FREE;
        endcase
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_FREE;
            len_q   <= '0;
            vis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            vis_q   <= vis_d;
        end
    end

    assign state   = state_q;
    assign len     = len_q;
    assign visible = vis_q && (state_q == SLOT_READY);

endmodule

// File: rtl/snoop_pkt_recorder.sv
// Two-slot recorder: a snooper fills a free slot word by word, a consumer drains completed packets oldest first.
// Latency: memory write 1 cycle after sn_wr_en; packet visible 2 cycles after sn_done.
// Backpressure: rdy_for_sn only while a slot is free; pkt_valid holds until pkt_ready; one packet read at a time.
module snoop_pkt_recorder
    import snoop_pkt_recorder_pkg::*;
#(
    parameter int SN_FWD_DATA_WIDTH = 64,
    parameter int SN_FWD_ADDR_WIDTH = 9,
    parameter int SN_INC_WIDTH      = 3,
    localparam int LEN_WIDTH = SN_FWD_ADDR_WIDTH + $clog2(SN_FWD_DATA_WIDTH / 8) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr,
    input  logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data,
    input  logic                         sn_wr_en,
    input  logic [SN_INC_WIDTH-1:0]      sn_byte_inc,
    input  logic                         sn_done,
    output logic                         rdy_for_sn,
    input  logic                         rdy_for_sn_ack,
    output logic [SN_FWD_ADDR_WIDTH:0]   mem_wr_addr,
    output logic [SN_FWD_DATA_WIDTH-1:0] mem_wr_data,
    output logic                         mem_wr_en,
    output logic                         pkt_valid,
    input  logic                         pkt_ready,
    output logic                         pkt_slot,
    output logic [LEN_WIDTH-1:0]         pkt_len,
    input  logic                         pkt_release
);

    localparam int unsigned BYTES_PER_WORD = SN_FWD_DATA_WIDTH / 8;

    logic [1:0]                   rst_sync_q, rst_sync_d;
    logic                         rst_n_int;
    sn_state_e                    sn_state_q, sn_state_d;
    logic                         fill_slot_q, fill_slot_d;
    logic                         first_q, first_d;
    logic                         mem_wr_en_q, mem_wr_en_d;
    logic [SN_FWD_ADDR_WIDTH:0]   mem_wr_addr_q, mem_wr_addr_d;
    logic [SN_FWD_DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
    slot_state_e                  slot_state [NUM_SLOTS];
    logic [LEN_WIDTH-1:0]         slot_len   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]         slot_vis;
    logic [NUM_SLOTS-1:0]         free_next;
    logic                         any_reading;
    logic                         start_fire, wr_fire, done_fire, take_fire;
    logic [LEN_WIDTH-1:0]         inc_bytes;

    // Reset asserts immediately but releases only after two clean edges.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // Reset synchroniser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= rst_sync_d;
    end

    assign rst_n_int = rst_sync_q[1];

    assign inc_bytes   = LEN_WIDTH'(decode_byte_inc(32'(sn_byte_inc), BYTES_PER_WORD));
    assign any_reading = (slot_state[0] == SLOT_READING) || (slot_state[1] == SLOT_READING);

    // A slot being released this cycle counts as free so it can be offered next cycle.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            free_next[i] = (slot_state[i] == SLOT_FREE) ||
                           ((slot_state[i] == SLOT_READING) && pkt_release);
        end
    end

    // Snoop FSM: pick lowest free slot, offer it, then accept writes until done.
    always_comb begin
        sn_state_d  = sn_state_q;
        fill_slot_d = fill_slot_q;
        start_fire  = 1'b0;
        wr_fire     = 1'b0;
        done_fire   = 1'b0;
        case (sn_state_q)
            SN_IDLE: begin
                if (|free_next) begin
                    sn_state_d  = SN_OFFER;
                    fill_slot_d = !free_next[0];
                end
            end
            SN_OFFER: begin
                if (rdy_for_sn_ack) begin
                    start_fire = 1'b1;
                    sn_state_d = SN_FILL;
                end
            end
            SN_FILL: begin
                wr_fire = sn_wr_en;
                if (sn_done) begin
                    done_fire  = 1'b1;
                    sn_state_d = SN_IDLE;
                end
            end
            default: sn_state_d = SN_IDLE;
        endcase
    end

    // Consumer side: the consumer holds at most one slot, so pkt_release is unambiguous.
    assign pkt_valid = slot_vis[first_q] && !any_reading;
    assign pkt_slot  = first_q;
    assign pkt_len   = slot_len[first_q];
    assign take_fire = pkt_valid && pkt_ready;

    // first_q always names the older READY slot; it moves only on take or completion.
    always_comb begin
        first_d = first_q;
        if (take_fire) begin
            first_d = !first_q;
        end
        if (done_fire) begin
            first_d = ((slot_state[!fill_slot_q] == SLOT_READY) && !take_fire) ? !fill_slot_q
                                                                               : fill_slot_q;
        end
    end

    // Registered memory write port.
    always_comb begin
        mem_wr_en_d   = wr_fire;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        if (wr_fire) begin
            mem_wr_addr_d = {fill_slot_q, sn_addr};
            mem_wr_data_d = sn_wr_data;
        end
    end

    // Control and write-port registers.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            sn_state_q    <= SN_IDLE;
            fill_slot_q   <= 1'b0;
            first_q       <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
        end else begin
            sn_state_q    <= sn_state_d;
            fill_slot_q   <= fill_slot_d;
            first_q       <= first_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign rdy_for_sn  = (sn_state_q == SN_OFFER);
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        pkt_slot_ctrl #(
            .LEN_WIDTH (LEN_WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n_int),
            .start     (start_fire && (fill_slot_q == 1'(i))),
            .add_en    (wr_fire && (fill_slot_q == 1'(i))),
            .add_bytes (inc_bytes),
            .done      (done_fire && (fill_slot_q == 1'(i))),
            .take      (take_fire && (first_q == 1'(i))),
            .rel       (pkt_release && (slot_state[i] == SLOT_READING)),
            .state     (slot_state[i]),
            .len       (slot_len[i]),
            .visible   (slot_vis[i])
        );
    end

endmodule

// File: tb/tb_snoop_pkt_recorder.sv
// Self-checking bench: directed scenarios plus random traffic against a packet-level reference model.
// Latency: n/a.
// Backpressure: consumer stalls pkt_ready randomly.
module tb_snoop_pkt_recorder;

    localparam int DW = 64;
    localparam int AW = 9;
    localparam int IW = 3;
    localparam int LW = 13;
    localparam int MAX_LEN = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] sn_addr = '0;
    logic [DW-1:0] sn_wr_data = '0;
    logic          sn_wr_en = 1'b0;
    logic [IW-1:0] sn_byte_inc = '0;
    logic          sn_done = 1'b0;
    logic          rdy_for_sn;
    logic          rdy_for_sn_ack = 1'b0;
    logic [AW:0]   mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_en;
    logic          pkt_valid;
    logic          pkt_ready = 1'b0;
    logic          pkt_slot;
    logic [LW-1:0] pkt_len;
    logic          pkt_release = 1'b0;

    always #5 clk = ~clk;

    snoop_pkt_recorder dut (
        .clk            (clk),
        .rst            (rst),
        .sn_addr        (sn_addr),
        .sn_wr_data     (sn_wr_data),
        .sn_wr_en       (sn_wr_en),
        .sn_byte_inc    (sn_byte_inc),
        .sn_done        (sn_done),
        .rdy_for_sn     (rdy_for_sn),
        .rdy_for_sn_ack (rdy_for_sn_ack),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_data    (mem_wr_data),
        .mem_wr_en      (mem_wr_en),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_slot       (pkt_slot),
        .pkt_len        (pkt_len),
        .pkt_release    (pkt_release)
    );

    typedef struct packed {
        logic [AW:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int slot;
        int len;
    } pkt_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    wr_t  exp_wr[$];
    pkt_t pq[$];
    int   inc_plan[$];
    bit   busy[2];
    int   rd_slot    = -1;
    int   offer_slot = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every memory write must match the next expected write, in order.
    always @(negedge clk) begin : mon_wr
        wr_t w;
        if (mem_wr_en) begin
            if (exp_wr.size() == 0) begin
                check_eq("unexpected_wr", 64'(mem_wr_en), 64'd0);
            end else begin
                w = exp_wr.pop_front();
                check_eq("wr_addr", 64'(mem_wr_addr), 64'(w.addr));
                check_eq("wr_data", mem_wr_data, w.data);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        sn_wr_en = 1'b0; sn_done = 1'b0; rdy_for_sn_ack = 1'b0;
        pkt_ready = 1'b0; pkt_release = 1'b0;
        repeat (3) tick();
        check_eq("rst_rdy", 64'(rdy_for_sn), 64'd0);
        check_eq("rst_wr_en", 64'(mem_wr_en), 64'd0);
        check_eq("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
        check_eq("rst_wr_data", mem_wr_data, 64'd0);
        check_eq("rst_pkt_valid", 64'(pkt_valid), 64'd0);
        check_eq("rst_pkt_slot", 64'(pkt_slot), 64'd0);
        check_eq("rst_pkt_len", 64'(pkt_len), 64'd0);
        exp_wr.delete(); pq.delete(); inc_plan.delete();
        busy[0] = 1'b0; busy[1] = 1'b0; rd_slot = -1; offer_slot = 0;
        rst = 1'b1;
        tick();
        check_eq("rdy_too_soon_after_rst", 64'(rdy_for_sn), 64'd0);
    endtask

    task automatic wait_offer(output bit ok);
        int n = 0;
        while (!rdy_for_sn && n < 20) begin
            tick();
            n++;
        end
        check_eq("offer", 64'(rdy_for_sn), 64'd1);
        ok = rdy_for_sn;
    endtask

    // One write of the current packet; returns the updated model length.
    task automatic put_word(input int slot, input int addr, input bit last_done,
                            input bit rel, inout int len);
        wr_t w;
        int  inc;
        inc = (inc_plan.size() > 0) ? inc_plan.pop_front() : int'($urandom_range(0, 7));
        len += (inc == 0) ? 8 : inc;
        if (len > MAX_LEN) len = MAX_LEN;
        sn_wr_en    = 1'b1;
        sn_addr     = AW'(addr % 512);
        sn_wr_data  = {$urandom, $urandom};
        sn_byte_inc = IW'(inc);
        w.addr = {1'(slot), sn_addr};
        w.data = sn_wr_data;
        exp_wr.push_back(w);
        if (last_done) begin
            sn_done     = 1'b1;
            pkt_release = rel;
        end
        tick();
        sn_wr_en = 1'b0; sn_done = 1'b0; pkt_release = 1'b0;
    endtask

    task automatic send_pkt(input int nwords, input int base, input bit done_with_last,
                            input bit gaps, input bit rel_at_done);
        int   slot;
        int   len = 0;
        bit   ok;
        pkt_t p;
        slot = offer_slot;
        wait_offer(ok);
        if (!ok || slot < 0) return;
        rdy_for_sn_ack = 1'b1;
        tick();
        rdy_for_sn_ack = 1'b0;
        offer_slot = -1;
        busy[slot] = 1'b1;
        for (int i = 0; i < nwords; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) tick();
            put_word(slot, base + i, (i == nwords - 1) && done_with_last, rel_at_done, len);
        end
        if (!done_with_last) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            sn_done     = 1'b1;
            pkt_release = rel_at_done;
            tick();
            sn_done = 1'b0; pkt_release = 1'b0;
        end
        if (pq.size() == 0) check_eq("visible_too_early", 64'(pkt_valid), 64'd0);
        if (rel_at_done && rd_slot >= 0) begin
            busy[rd_slot] = 1'b0;
            rd_slot = -1;
        end
        p.slot = slot;
        p.len  = len;
        pq.push_back(p);
        if (!busy[0]) offer_slot = 0;
        else if (!busy[1]) offer_slot = 1;
    endtask

    task automatic take_pkt(input int stall);
        pkt_t p;
        int   n = 0;
        while (!pkt_valid && n < 10) begin
            tick();
            n++;
        end
        check_eq("pkt_valid", 64'(pkt_valid), 64'd1);
        p = pq.pop_front();
        check_eq("pkt_slot", 64'(pkt_slot), 64'(p.slot));
        check_eq("pkt_len", 64'(pkt_len), 64'(p.len));
        repeat (stall) begin
            tick();
            check_eq("hold_valid", 64'(pkt_valid), 64'd1);
            check_eq("hold_slot", 64'(pkt_slot), 64'(p.slot));
            check_eq("hold_len", 64'(pkt_len), 64'(p.len));
        end
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        rd_slot = p.slot;
    endtask

    task automatic release_pkt();
        bit both;
        both = busy[0] && busy[1];
        if (both) check_eq("rdy_with_no_free", 64'(rdy_for_sn), 64'd0);
        pkt_release = 1'b1;
        tick();
        pkt_release = 1'b0;
        busy[rd_slot] = 1'b0;
        if (offer_slot < 0) offer_slot = rd_slot;
        rd_slot = -1;
        if (both) check_eq("rdy_after_release", 64'(rdy_for_sn), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int len;
        do_reset();

        // Strobes outside FILL (here in OFFER) are ignored.
        wait_offer(ok);
        sn_wr_en = 1'b1; sn_done = 1'b1; sn_wr_data = {$urandom, $urandom};
        repeat (2) tick();
        sn_wr_en = 1'b0; sn_done = 1'b0;
        check_eq("offer_kept", 64'(rdy_for_sn), 64'd1);
        check_eq("no_pkt_from_offer", 64'(pkt_valid), 64'd0);

        // Three words, increments 0,0,5 -> 21 bytes in slot 0.
        inc_plan = '{0, 0, 5};
        send_pkt(3, 0, 1'b0, 1'b0, 1'b0);
        take_pkt(2);
        release_pkt();

        // Two packets without pkt_ready; older first; strobes while no slot is free are ignored.
        do_reset();
        send_pkt(2, 40, 1'b0, 1'b0, 1'b0);
        send_pkt(3, 80, 1'b0, 1'b0, 1'b0);
        sn_wr_en = 1'b1; sn_done = 1'b1; sn_wr_data = {$urandom, $urandom};
        repeat (3) begin
            tick();
            check_eq("rdy_both_full", 64'(rdy_for_sn), 64'd0);
        end
        sn_wr_en = 1'b0; sn_done = 1'b0;
        take_pkt(1);
        release_pkt();
        take_pkt(0);
        release_pkt();

        // Write and sn_done in the same cycle, slot 1.
        do_reset();
        send_pkt(2, 7, 1'b0, 1'b0, 1'b0);
        inc_plan = '{4, 3};
        send_pkt(2, 300, 1'b1, 1'b0, 1'b0);
        take_pkt(0);
        release_pkt();
        take_pkt(0);
        release_pkt();

        // sn_done on slot 1 in the same cycle as pkt_release of slot 0.
        do_reset();
        send_pkt(3, 0, 1'b0, 1'b0, 1'b0);
        take_pkt(0);
        send_pkt(2, 100, 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("rdy_after_done_release", 64'(rdy_for_sn), 64'd1);
        take_pkt(0);
        send_pkt(1, 200, 1'b0, 1'b0, 1'b0);
        release_pkt();
        take_pkt(0);
        release_pkt();

        // Length saturation.
        do_reset();
        for (int i = 0; i < 1100; i++) inc_plan.push_back(0);
        send_pkt(1100, 0, 1'b1, 1'b0, 1'b0);
        take_pkt(0);
        release_pkt();

        // Reset in the middle of a fill, then a fresh packet.
        wait_offer(ok);
        rdy_for_sn_ack = 1'b1;
        tick();
        rdy_for_sn_ack = 1'b0;
        len = 0;
        for (int i = 0; i < 4; i++) put_word(offer_slot, i, 1'b0, 1'b0, len);
        do_reset();
        inc_plan = '{1, 2};
        send_pkt(2, 10, 1'b0, 1'b0, 1'b0);
        take_pkt(1);
        release_pkt();

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            int r;
            bit rel;
            r = int'($urandom_range(0, 3));
            if (r <= 1 && offer_slot >= 0) begin
                rel = (rd_slot >= 0) && ($urandom_range(0, 1) == 1);
                send_pkt(int'($urandom_range(1, 8)), int'($urandom_range(0, 511)),
                         bit'($urandom_range(0, 1)), 1'b1, rel);
            end else if (rd_slot >= 0) begin
                release_pkt();
            end else if (pq.size() > 0) begin
                take_pkt(int'($urandom_range(0, 3)));
            end else begin
                tick();
            end
        end
        for (int k = 0; k < 8 && (pq.size() > 0 || rd_slot >= 0); k++) begin
            if (rd_slot >= 0) release_pkt();
            else take_pkt(0);
        end
        repeat (3) tick();
        check_eq("writes_drained", 64'(exp_wr.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/snoop_pkt_recorder.md
SNOOP_PKT_RECORDER -- requirements
Module: snoop_pkt_recorder

Interface
REQ-001 SHALL have parameter SN_FWD_DATA_WIDTH, default 64, snoop write-data width in bits.
REQ-002 SHALL have parameter SN_FWD_ADDR_WIDTH, default 9, per-slot word-address width.
REQ-003 SHALL have parameter SN_INC_WIDTH, default 3, byte-increment width.
REQ-004 SHALL define LEN_WIDTH = SN_FWD_ADDR_WIDTH + log2(SN_FWD_DATA_WIDTH/8) + 1.
REQ-005 SHALL have clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have sn_addr  input  SN_FWD_ADDR_WIDTH  word address within current slot.
REQ-008 SHALL have sn_wr_data  input  SN_FWD_DATA_WIDTH  word to store.
REQ-009 SHALL have sn_wr_en  input  1  write strobe.
REQ-010 SHALL have sn_byte_inc  input  SN_INC_WIDTH  valid bytes in this word; 0 means SN_FWD_DATA_WIDTH/8.
REQ-011 SHALL have sn_done  input  1  packet complete pulse.
REQ-012 SHALL have rdy_for_sn  output  1  free slot offered to snooper.
REQ-013 SHALL have rdy_for_sn_ack  input  1  snooper accepts offer.
REQ-014 SHALL have mem_wr_addr  output  SN_FWD_ADDR_WIDTH+1  {slot, sn_addr}.
REQ-015 SHALL have mem_wr_data  output  SN_FWD_DATA_WIDTH;  mem_wr_en  output  1.
REQ-016 SHALL have pkt_valid  output  1;  pkt_ready  input  1  completed-packet handshake.
REQ-017 SHALL have pkt_slot  output  1;  pkt_len  output  LEN_WIDTH  packet byte length.
REQ-018 SHALL have pkt_release  input  1  consumer frees slot in READING.

Function
REQ-019 Each of two slots SHALL hold state FREE, FILLING, READY or READING.
REQ-020 Snoop FSM SHALL use IDLE, OFFER, FILL; IDLE->OFFER when any slot FREE, lowest-index FREE slot chosen.
REQ-021 rdy_for_sn SHALL be 1 exactly in OFFER; OFFER->FILL on rdy_for_sn_ack, chosen slot -> FILLING, length cleared.
REQ-022 In FILL, sn_wr_en SHALL produce mem_wr_en one cycle later with registered {slot, sn_addr} and data.
REQ-023 In FILL, each sn_wr_en SHALL add decoded sn_byte_inc to length, saturating at 2^LEN_WIDTH-1.
REQ-024 sn_done in FILL SHALL latch slot length (including any same-cycle write), slot -> READY, FSM -> IDLE.
REQ-025 sn_wr_en and sn_done outside FILL SHALL be ignored (no memory write, no state change).
REQ-026 READY slot SHALL become visible (pkt_valid=1) no earlier than two cycles after sn_done, after its last memory write.
REQ-027 With two READY slots, pkt_valid SHALL present the older completion first.
REQ-028 pkt_slot and pkt_len SHALL be stable while pkt_valid=1 and pkt_ready=0.
REQ-029 pkt_valid&pkt_ready SHALL move slot READY->READING; pkt_release SHALL move READING->FREE, else ignored.
REQ-030 Simultaneous sn_done on one slot and pkt_release on the other SHALL both take effect in that cycle.
REQ-031 A slot freed by pkt_release SHALL be offerable in the next cycle (rdy_for_sn at release+1 earliest).
REQ-032 With no FREE slot, rdy_for_sn SHALL stay 0.

Reset
REQ-033 rst=0 SHALL force FSM IDLE, both slots FREE, age bit 0, lengths 0, all outputs 0, regardless of mid-packet state.
REQ-034 Deassertion SHALL be synchronous to clk; first rdy_for_sn no earlier than second edge after deassertion.

Structure
REQ-035 Shared package SHALL hold slot-state and snoop-FSM encodings plus byte-increment decode function.
REQ-036 One sub-module pkt_slot_ctrl (per-slot state and length register) SHALL be instantiated twice.

Verification
REQ-037 Reset, ack, 3 writes inc 0,0,5 then sn_done -> mem_wr_en 3 cycles addr 0x000..0x002, pkt_valid pkt_slot=0 pkt_len=21.
REQ-038 Two packets, no pkt_ready -> second fills slot 1, rdy_for_sn stays 0, pkt_slot=0 presented first.
REQ-039 Write and sn_done same cycle, inc 3 -> pkt_len includes 3 bytes; mem_wr_addr MSB = slot.
REQ-040 sn_done on slot 1 same cycle as pkt_release of slot 0 -> slot 0 FREE, slot 1 READY, rdy_for_sn next cycle.
REQ-041 rst low mid-FILL after 4 writes -> all outputs 0, no pkt_valid; new packet lands in slot 0 with fresh length.
REQ-042 sn_wr_en/sn_done while IDLE -> no mem_wr_en, no state change, pkt_valid stays 0.
